// File: rtl/alu_integer_iterative_pkg.sv
// Shared encodings for the iterative integer ALU: opcodes, funct3/funct7 codes, FSM states.
package alu_integer_iterative_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_integer_iterative_if.sv
// Request/response bundle between register-read, the ALU and writeback.
interface alu_integer_iterative_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      subfunction_3;
  logic [6:0]      subfunction_7;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] itype_immediate;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_to_write_rd;
  logic            decoding_error;

  modport master (
    output in_valid, opcode, subfunction_3, subfunction_7,
           rs1_value, rs2_value, itype_immediate, out_ready,
    input  in_ready, out_valid, result_to_write_rd, decoding_error
  );

  modport slave (
    input  in_valid, opcode, subfunction_3, subfunction_7,
           rs1_value, rs2_value, itype_immediate, out_ready,
    output in_ready, out_valid, result_to_write_rd, decoding_error
  );
endinterface

// File: rtl/alu_iterative_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle; the first step is taken
// on the start cycle so that latency is ceil(shamt/SHIFT_STEP).
module alu_iterative_shifter
  import alu_integer_iterative_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int SHAMT_W    = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               left_i,
  input  logic               arith_i,
  input  logic [XLEN-1:0]    operand_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    result_o
);
  // One extra bit so a single-pass step of XLEN still fits in the counter.
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  logic [XLEN-1:0]  work_q, work_d, src;
  logic [CNT_W-1:0] remain_q, remain_d, rem, step;
  logic             left_q, fill_q, busy_q, busy_d;
  logic             left_s, fill_s, active;

  always_comb begin
    active   = start_i || busy_q;
    src      = start_i ? operand_i : work_q;
    rem      = start_i ? {1'b0, shamt_i} : remain_q;
    left_s   = start_i ? left_i : left_q;
    fill_s   = start_i ? (arith_i & operand_i[XLEN-1]) : fill_q;
    step     = (rem > STEP_C) ? STEP_C : rem;
    if (left_s) begin
      work_d = src << step;
    end else if (fill_s) begin
      work_d = ~((~src) >> step);
    end else begin
      work_d = src >> step;
    end
    remain_d = rem - step;
    busy_d   = active && (rem > STEP_C);
  end

  assign done_o   = active && (rem <= STEP_C);
  assign busy_o   = busy_q;
  assign result_o = work_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work_q   <= '0;
      remain_q <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (active) begin
      work_q   <= work_d;
      remain_q <= remain_d;
      left_q   <= left_s;
      fill_q   <= fill_s;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_integer_iterative.sv
// Integer ALU for OP and OP-IMM with valid/ready handshakes; single-cycle ops are
// computed here, shifts longer than one step are handed to the iterative shifter.
module alu_integer_iterative
  import alu_integer_iterative_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  alu_integer_iterative_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int QUAL_W  = 12 - SHAMT_W;
  localparam logic [QUAL_W-1:0] SRAI_QUAL = F7_ALT[6:SHAMT_W-5];

  alu_state_e      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            err_q, err_d;

  logic            is_op, is_imm, is_shift, legal, is_sub, is_sra, accept, sh_start;
  logic [QUAL_W-1:0] qual;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  logic            sh_busy, sh_done;
  logic [XLEN-1:0] sh_result;

  assign bus.in_ready           = (state_q == ST_IDLE) && !sh_busy && (!out_valid_q || bus.out_ready);
  assign bus.out_valid          = out_valid_q;
  assign bus.result_to_write_rd = result_q;
  assign bus.decoding_error     = err_q;
  assign accept                 = bus.in_valid && bus.in_ready;

  always_comb begin
    is_op    = (bus.opcode == OPC_OP);
    is_imm   = (bus.opcode == OPC_OP_IMM);
    is_shift = (bus.subfunction_3 == F3_SLL) || (bus.subfunction_3 == F3_SR);
    qual     = bus.itype_immediate[11:SHAMT_W];
    op_a     = bus.rs1_value;
    op_b     = is_op ? bus.rs2_value : bus.itype_immediate;
    legal    = 1'b0;
    if (is_op) begin
      legal = (bus.subfunction_7 == F7_BASE) ||
              ((bus.subfunction_7 == F7_ALT) &&
               ((bus.subfunction_3 == F3_ADD) || (bus.subfunction_3 == F3_SR)));
    end else if (is_imm) begin
      if (!is_shift) begin
        legal = 1'b1;
      end else begin
        legal = (qual == '0) || ((bus.subfunction_3 == F3_SR) && (qual == SRAI_QUAL));
      end
    end
    is_sub = is_op && (bus.subfunction_7 == F7_ALT);
    is_sra = (bus.subfunction_3 == F3_SR) &&
             (is_op ? (bus.subfunction_7 == F7_ALT) : (qual == SRAI_QUAL));
  end

  always_comb begin
    alu_res = '0;
    case (bus.subfunction_3)
      F3_ADD:  alu_res = is_sub ? (op_a - op_b) : (op_a + op_b);
      F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      F3_XOR:  alu_res = op_a ^ op_b;
      F3_OR:   alu_res = op_a | op_b;
      F3_AND:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  assign sh_start = accept && legal && is_shift;

  alu_iterative_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP),
    .SHAMT_W    (SHAMT_W)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (sh_start),
    .left_i    (bus.subfunction_3 == F3_SLL),
    .arith_i   (is_sra),
    .operand_i (op_a),
    .shamt_i   (op_b[SHAMT_W-1:0]),
    .busy_o    (sh_busy),
    .done_o    (sh_done),
    .result_o  (sh_result)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    err_d       = err_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (sh_start && !sh_done) begin
            state_d = ST_SHIFT;
          end else begin
            out_valid_d = 1'b1;
            err_d       = !legal;
            result_d    = !legal ? '0 : (is_shift ? sh_result : alu_res);
          end
        end
      end
      ST_SHIFT: begin
        // Output register is empty here: a request is only accepted once it drained.
        if (sh_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          err_d       = 1'b0;
          result_d    = sh_result;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_integer_iterative.sv
// Directed vectors for the iterative ALU on two instances (1-bit and 4-bit shift steps).
module tb_alu_integer_iterative;
  import alu_integer_iterative_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_integer_iterative_if #(.XLEN(32)) if1 ();
  alu_integer_iterative_if #(.XLEN(32)) if4 ();

  alu_integer_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave));
  alu_integer_iterative #(.XLEN(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4.slave));

  logic        use4 = 1'b0;
  logic        in_valid_t = 1'b0;
  logic        out_ready_t = 1'b1;
  logic [6:0]  opc_t = '0;
  logic [2:0]  f3_t = '0;
  logic [6:0]  f7_t = '0;
  logic [31:0] rs1_t = '0, rs2_t = '0, imm_t = '0;

  assign if1.in_valid = in_valid_t & ~use4;
  assign if4.in_valid = in_valid_t & use4;
  assign if1.out_ready = out_ready_t;
  assign if4.out_ready = out_ready_t;
  assign if1.opcode = opc_t;          assign if4.opcode = opc_t;
  assign if1.subfunction_3 = f3_t;    assign if4.subfunction_3 = f3_t;
  assign if1.subfunction_7 = f7_t;    assign if4.subfunction_7 = f7_t;
  assign if1.rs1_value = rs1_t;       assign if4.rs1_value = rs1_t;
  assign if1.rs2_value = rs2_t;       assign if4.rs2_value = rs2_t;
  assign if1.itype_immediate = imm_t; assign if4.itype_immediate = imm_t;

  logic        o_valid, o_ready_in, o_err;
  logic [31:0] o_res;
  assign o_valid    = use4 ? if4.out_valid : if1.out_valid;
  assign o_ready_in = use4 ? if4.in_ready : if1.in_ready;
  assign o_err      = use4 ? if4.decoding_error : if1.decoding_error;
  assign o_res      = use4 ? if4.result_to_write_rd : if1.result_to_write_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    bit          u4;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] res;
    bit          err;
    int          lat;
  } vec_t;

  localparam logic [6:0] OPC_LUI = 7'b0110111;

  vec_t vecs[19];

  initial begin
    int lat;
    bit busy_ready;

    vecs[0]  = '{"addi_wrap", 0, OPC_OP_IMM, F3_ADD,  7'h00, 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h00000000, 0, 1};
    vecs[1]  = '{"sub",       0, OPC_OP,     F3_ADD,  F7_ALT, 32'd5, 32'd7, 32'h0, 32'hFFFFFFFE, 0, 1};
    vecs[2]  = '{"slt",       0, OPC_OP,     F3_SLT,  F7_BASE, 32'd5, 32'd7, 32'h0, 32'h1, 0, 1};
    vecs[3]  = '{"sltu",      0, OPC_OP,     F3_SLTU, F7_BASE, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 0, 1};
    vecs[4]  = '{"slti_neg",  0, OPC_OP_IMM, F3_SLT,  7'h00, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 0, 1};
    vecs[5]  = '{"xori",      0, OPC_OP_IMM, F3_XOR,  7'h00, 32'h0F0F00FF, 32'h0, 32'hFFFFF800, 32'hF0F0F8FF, 0, 1};
    vecs[6]  = '{"or",        0, OPC_OP,     F3_OR,   F7_BASE, 32'h12340000, 32'h00005678, 32'h0, 32'h12345678, 0, 1};
    vecs[7]  = '{"andi",      0, OPC_OP_IMM, F3_AND,  7'h00, 32'hDEADBEEF, 32'h0, 32'h000000FF, 32'h000000EF, 0, 1};
    vecs[8]  = '{"addi_f7ign",0, OPC_OP_IMM, F3_ADD,  7'h7F, 32'd10, 32'h0, 32'hFFFFFFFD, 32'd7, 0, 1};
    vecs[9]  = '{"srai31_s1", 0, OPC_OP_IMM, F3_SR,   7'h00, 32'h80000000, 32'h0, 32'h0000041F, 32'hFFFFFFFF, 0, 31};
    vecs[10] = '{"srli4",     0, OPC_OP_IMM, F3_SR,   7'h00, 32'h80000000, 32'h0, 32'h00000004, 32'h08000000, 0, 4};
    vecs[11] = '{"sll_r",     0, OPC_OP,     F3_SLL,  F7_BASE, 32'h1, 32'hFFFFFFE3, 32'h0, 32'h00000008, 0, 3};
    vecs[12] = '{"sra_r",     0, OPC_OP,     F3_SR,   F7_ALT, 32'hF0000000, 32'd8, 32'h0, 32'hFFF00000, 0, 8};
    vecs[13] = '{"srl_r1",    0, OPC_OP,     F3_SR,   F7_BASE, 32'h80000000, 32'd1, 32'h0, 32'h40000000, 0, 1};
    vecs[14] = '{"slli0",     0, OPC_OP_IMM, F3_SLL,  7'h00, 32'h00001234, 32'h0, 32'h0, 32'h00001234, 0, 1};
    vecs[15] = '{"srli_badq", 0, OPC_OP_IMM, F3_SR,   7'h00, 32'hFFFFFFFF, 32'h0, 32'h00000021, 32'h0, 1, 1};
    vecs[16] = '{"add_badf7", 0, OPC_OP,     F3_ADD,  7'h01, 32'd3, 32'd4, 32'h0, 32'h0, 1, 1};
    vecs[17] = '{"bad_opc",   0, OPC_LUI,    F3_ADD,  7'h00, 32'd3, 32'd4, 32'h0, 32'h0, 1, 1};
    vecs[18] = '{"srai31_s4", 1, OPC_OP_IMM, F3_SR,   7'h00, 32'h80000000, 32'h0, 32'h0000041F, 32'hFFFFFFFF, 0, 8};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, if1.out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, if1.in_ready}, 32'd1);
    check("rst_result", if1.result_to_write_rd, 32'd0);
    check("rst_err", {31'b0, if1.decoding_error}, 32'd0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      use4 = vecs[i].u4;
      opc_t = vecs[i].opc; f3_t = vecs[i].f3; f7_t = vecs[i].f7;
      rs1_t = vecs[i].rs1; rs2_t = vecs[i].rs2; imm_t = vecs[i].imm;
      in_valid_t = 1'b1;
      #1;
      check({vecs[i].name, "_accept_ready"}, {31'b0, o_ready_in}, 32'd1);
      tick();
      in_valid_t = 1'b0;
      lat = 1;
      busy_ready = 1'b0;
      while (!o_valid && lat < 100) begin
        if (o_ready_in) busy_ready = 1'b1;
        tick();
        lat++;
      end
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_result"}, o_res, vecs[i].res);
      check({vecs[i].name, "_err"}, {31'b0, o_err}, {31'b0, vecs[i].err});
      if (vecs[i].lat > 1) check({vecs[i].name, "_inready_busy"}, {31'b0, busy_ready}, 32'd0);
      $display("[TB] %s: result=0x%08h err=%0d latency=%0d", vecs[i].name, o_res, o_err, lat);
      tick();
      check({vecs[i].name, "_drained"}, {31'b0, o_valid}, 32'd0);
    end

    // 4-bit step, shamt below the step: single pass, latency 1.
    use4 = 1'b1;
    opc_t = OPC_OP_IMM; f3_t = F3_SR; f7_t = 7'h00; rs1_t = 32'hF0; imm_t = 32'h3;
    in_valid_t = 1'b1;
    tick();
    in_valid_t = 1'b0;
    check("s4_short_valid", {31'b0, o_valid}, 32'd1);
    check("s4_short_result", o_res, 32'h1E);
    $display("[TB] s4_short: result=0x%08h", o_res);
    tick();
    use4 = 1'b0;

    // Back-pressure: result held while out_ready is low, then consume+accept together.
    out_ready_t = 1'b0;
    opc_t = OPC_OP; f3_t = F3_ADD; f7_t = F7_BASE; rs1_t = 32'd1; rs2_t = 32'd2;
    in_valid_t = 1'b1;
    tick();
    in_valid_t = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid_held", {31'b0, o_valid}, 32'd1);
      check("bp_result_held", o_res, 32'd3);
      check("bp_in_ready_low", {31'b0, o_ready_in}, 32'd0);
      tick();
    end
    rs1_t = 32'd10; rs2_t = 32'd20;
    in_valid_t = 1'b1;
    out_ready_t = 1'b1;
    #1;
    check("bp_ready_on_release", {31'b0, o_ready_in}, 32'd1);
    tick();
    in_valid_t = 1'b0;
    check("bp_next_valid", {31'b0, o_valid}, 32'd1);
    check("bp_next_result", o_res, 32'd30);
    $display("[TB] backpressure: next result=0x%08h", o_res);
    tick();

    // Reset during an SLLI by 20 must abandon it.
    opc_t = OPC_OP_IMM; f3_t = F3_SLL; f7_t = 7'h00; rs1_t = 32'h1; imm_t = 32'h14;
    in_valid_t = 1'b1;
    tick();
    in_valid_t = 1'b0;
    repeat (5) tick();
    check("rs_mid_busy", {31'b0, o_ready_in}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("rs_out_valid", {31'b0, o_valid}, 32'd0);
    check("rs_in_ready", {31'b0, o_ready_in}, 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    busy_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (o_valid) busy_ready = 1'b1;
      tick();
    end
    check("rs_no_result", {31'b0, busy_ready}, 32'd0);
    $display("[TB] reset_mid_shift: out_valid_seen=%0d", busy_ready);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
